// File: rtl/intra4x4_mode_decider.sv
// Intra 4x4 luma mode decision: evaluates one prediction mode per cycle, keeps the lowest SAD.
// Define INTRA4X4_DDL_EN to add diagonal-down-left as a fourth candidate mode.
module intra4x4_mode_decider #(
  parameter int PIX_W      = 8,
  parameter int DC_DEFAULT = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [16*PIX_W-1:0]     mb_in,
  input  logic [8*PIX_W-1:0]      top_in,
  input  logic [5*PIX_W-1:0]      left_in,
  input  logic                    top_avail,
  input  logic                    top_right_avail,
  input  logic                    left_avail,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              best_mode,
  output logic [PIX_W+3:0]        best_sad,
  output logic [16*PIX_W-1:0]     pred_out,
  output logic [16*(PIX_W+1)-1:0] resid_out,
  output logic [1:0]              dbg_state
);
  localparam int SW = PIX_W + 4;
  localparam int RW = PIX_W + 1;
`ifdef INTRA4X4_DDL_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
  localparam logic       DDL_ON   = 1'b1;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
  localparam logic       DDL_ON   = 1'b0;
`endif

  // Handshake: a transfer happens on a rising edge where valid && ready; ready is
  // high only in IDLE (input side), valid only in DONE (output side), never both.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EVAL = 2'd1, S_DONE = 2'd2} state_t;

  state_t                 r_state;
  logic [1:0]             r_idx;
  logic [PIX_W-1:0]       r_mb [16];
  logic [PIX_W-1:0]       r_top [8];
  logic [PIX_W-1:0]       r_left [4];
  logic                   r_top_av, r_tr_av, r_left_av;
  logic [SW-1:0]          r_best_sad_run;
  logic [1:0]             r_best_mode_run;
  logic [PIX_W-1:0]       r_best_pred [16];
  logic                   r_out_valid;
  logic [1:0]             r_best_mode;
  logic [SW-1:0]          r_best_sad;
  logic [16*PIX_W-1:0]    r_pred_out;
  logic [16*RW-1:0]       r_resid_out;

  logic [PIX_W-1:0]       w_p [9];
  logic [PIX_W+2:0]       w_dc_sum;
  logic [PIX_W-1:0]       w_dc;
  logic [PIX_W+1:0]       w_ddl [16];
  logic [PIX_W-1:0]       w_pred [16];
  logic [PIX_W-1:0]       w_diff;
  logic [SW-1:0]          w_sad;
  logic                   w_legal, w_take;
  logic [PIX_W-1:0]       w_fin_pred [16];
  logic [1:0]             w_fin_mode;
  logic [SW-1:0]          w_fin_sad;
  logic [16*PIX_W-1:0]    w_pred_pk;
  logic [16*RW-1:0]       w_resid_pk;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign best_mode = r_best_mode;
  assign best_sad  = r_best_sad;
  assign pred_out  = r_pred_out;
  assign resid_out = r_resid_out;
  assign dbg_state = r_state;

  // p[8] duplicates p[7] so the (3,3) corner fits the general 3-tap filter.
  always_comb begin
    for (int i = 0; i < 8; i++) w_p[i] = (i >= 4 && !r_tr_av) ? r_top[3] : r_top[i];
    w_p[8] = w_p[7];
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        w_ddl[4*y+x] = {2'b00, w_p[x+y]} + {1'b0, w_p[x+y+1], 1'b0}
                     + {2'b00, w_p[x+y+2]} + (PIX_W+2)'(2);
  end

  always_comb begin
    w_dc_sum = '0;
    w_dc     = PIX_W'(DC_DEFAULT);
    if (r_top_av && r_left_av) begin
      for (int i = 0; i < 4; i++)
        w_dc_sum = w_dc_sum + (PIX_W+3)'(r_top[i]) + (PIX_W+3)'(r_left[i]);
      w_dc_sum = w_dc_sum + (PIX_W+3)'(4);
      w_dc     = w_dc_sum[PIX_W+2:3];
    end else if (r_top_av) begin
      for (int i = 0; i < 4; i++) w_dc_sum = w_dc_sum + (PIX_W+3)'(r_top[i]);
      w_dc_sum = w_dc_sum + (PIX_W+3)'(2);
      w_dc     = w_dc_sum[PIX_W+1:2];
    end else if (r_left_av) begin
      for (int i = 0; i < 4; i++) w_dc_sum = w_dc_sum + (PIX_W+3)'(r_left[i]);
      w_dc_sum = w_dc_sum + (PIX_W+3)'(2);
      w_dc     = w_dc_sum[PIX_W+1:2];
    end
  end

  always_comb begin
    w_diff = '0;
    w_sad  = '0;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        case (r_idx)
          2'd0:    w_pred[4*y+x] = r_top[x];
          2'd1:    w_pred[4*y+x] = r_left[y];
          2'd2:    w_pred[4*y+x] = w_dc;
          default: w_pred[4*y+x] = w_ddl[4*y+x][PIX_W+1:2];
        endcase
      end
    end
    for (int i = 0; i < 16; i++) begin
      w_diff = (r_mb[i] >= w_pred[i]) ? (r_mb[i] - w_pred[i]) : (w_pred[i] - r_mb[i]);
      w_sad  = w_sad + SW'(w_diff);
    end
  end

  // Strict less-than keeps the earlier (lower-numbered) mode on ties.
  always_comb begin
    case (r_idx)
      2'd0:    w_legal = r_top_av;
      2'd1:    w_legal = r_left_av;
      2'd2:    w_legal = 1'b1;
      default: w_legal = DDL_ON && r_top_av;
    endcase
    w_take     = w_legal && (w_sad < r_best_sad_run);
    w_fin_mode = w_take ? r_idx : r_best_mode_run;
    w_fin_sad  = w_take ? w_sad : r_best_sad_run;
    w_pred_pk  = '0;
    w_resid_pk = '0;
    for (int i = 0; i < 16; i++) begin
      w_fin_pred[i] = w_take ? w_pred[i] : r_best_pred[i];
      w_pred_pk[i*PIX_W +: PIX_W] = w_fin_pred[i];
      w_resid_pk[i*RW +: RW]      = {1'b0, r_mb[i]} - {1'b0, w_fin_pred[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_idx           <= '0;
      r_top_av        <= 1'b0;
      r_tr_av         <= 1'b0;
      r_left_av       <= 1'b0;
      r_best_sad_run  <= '1;
      r_best_mode_run <= '0;
      for (int i = 0; i < 16; i++) begin
        r_mb[i]        <= '0;
        r_best_pred[i] <= '0;
      end
      for (int i = 0; i < 8; i++) r_top[i] <= '0;
      for (int i = 0; i < 4; i++) r_left[i] <= '0;
      r_out_valid <= 1'b0;
      r_best_mode <= '0;
      r_best_sad  <= '0;
      r_pred_out  <= '0;
      r_resid_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          for (int i = 0; i < 16; i++) r_mb[i] <= mb_in[i*PIX_W +: PIX_W];
          for (int i = 0; i < 8; i++) r_top[i] <= top_in[i*PIX_W +: PIX_W];
          for (int i = 0; i < 4; i++) r_left[i] <= left_in[(i+1)*PIX_W +: PIX_W];
          r_top_av        <= top_avail;
          r_tr_av         <= top_right_avail;
          r_left_av       <= left_avail;
          r_idx           <= '0;
          r_best_sad_run  <= '1;
          r_best_mode_run <= '0;
          r_state         <= S_EVAL;
        end
        S_EVAL: begin
          if (w_take) begin
            r_best_sad_run  <= w_sad;
            r_best_mode_run <= r_idx;
            for (int i = 0; i < 16; i++) r_best_pred[i] <= w_pred[i];
          end
          if (r_idx == LAST_IDX) begin
            r_best_mode <= w_fin_mode;
            r_best_sad  <= w_fin_sad;
            r_pred_out  <= w_pred_pk;
            r_resid_out <= w_resid_pk;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        S_DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_intra4x4_mode_decider.sv
// Bench for intra4x4_mode_decider: scoreboard against a mode-by-mode reference model.
module tb_intra4x4_mode_decider;
`ifdef INTRA4X4_DDL_EN
  localparam int NM = 4;
`else
  localparam int NM = 3;
`endif
  localparam int EW = 286;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] mb_in = '0;
  logic [63:0]  top_in = '0;
  logic [39:0]  left_in = '0;
  logic         top_avail = 1'b0, top_right_avail = 1'b0, left_avail = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [1:0]   best_mode;
  logic [11:0]  best_sad;
  logic [127:0] pred_out;
  logic [143:0] resid_out;
  logic [1:0]   dbg_state;

  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  int            checks = 0, failures = 0, cyc = 0;
  bit            rdy_rand = 1'b1, rdy_force = 1'b1, prev_valid = 1'b0;

  intra4x4_mode_decider dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mb_in(mb_in), .top_in(top_in), .left_in(left_in),
    .top_avail(top_avail), .top_right_avail(top_right_avail), .left_avail(left_avail),
    .out_valid(out_valid), .out_ready(out_ready), .best_mode(best_mode),
    .best_sad(best_sad), .pred_out(pred_out), .resid_out(resid_out), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string nm, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: build every mode's 4x4 prediction, score it, keep the first strictly-best legal one.
  function automatic logic [EW-1:0] model(input logic [127:0] mb, input logic [63:0] top,
                                          input logic [39:0] left, input bit ta, input bit tra, input bit la);
    int t[8]; int l[4]; int m[16]; int pp[8]; int pr[4][16];
    int dc, sad, bm, bs, d, x, y;
    bit legal;
    logic [127:0] pk;
    logic [143:0] rk;
    for (int i = 0; i < 8; i++) t[i] = int'(top[8*i +: 8]);
    for (int i = 0; i < 4; i++) l[i] = int'(left[8*(i+1) +: 8]);
    for (int i = 0; i < 16; i++) m[i] = int'(mb[8*i +: 8]);
    for (int i = 0; i < 8; i++) pp[i] = (i >= 4 && !tra) ? t[3] : t[i];
    if (ta && la)  dc = (t[0] + t[1] + t[2] + t[3] + l[0] + l[1] + l[2] + l[3] + 4) / 8;
    else if (ta)   dc = (t[0] + t[1] + t[2] + t[3] + 2) / 4;
    else if (la)   dc = (l[0] + l[1] + l[2] + l[3] + 2) / 4;
    else           dc = 128;
    for (int i = 0; i < 16; i++) begin
      x = i % 4; y = i / 4;
      pr[0][i] = t[x];
      pr[1][i] = l[y];
      pr[2][i] = dc;
      if (x == 3 && y == 3) pr[3][i] = (pp[6] + 3 * pp[7] + 2) / 4;
      else                  pr[3][i] = (pp[x+y] + 2 * pp[x+y+1] + pp[x+y+2] + 2) / 4;
    end
    bm = -1; bs = 0;
    for (int md = 0; md < NM; md++) begin
      legal = (md == 0) ? ta : (md == 1) ? la : (md == 2) ? 1'b1 : ta;
      sad = 0;
      for (int i = 0; i < 16; i++) begin
        d = m[i] - pr[md][i];
        sad += (d < 0) ? -d : d;
      end
      if (legal && (bm < 0 || sad < bs)) begin bm = md; bs = sad; end
    end
    for (int i = 0; i < 16; i++) begin
      pk[8*i +: 8] = 8'(pr[bm][i]);
      rk[9*i +: 9] = 9'(m[i] - pr[bm][i]);
    end
    return {2'(bm), 12'(bs), pk, rk};
  endfunction

  // driver
  task automatic send(input logic [127:0] mb, input logic [63:0] top, input logic [39:0] left,
                      input bit ta, input bit tra, input bit la, input bit push);
    int n;
    mb_in = mb; top_in = top; left_in = left;
    top_avail = ta; top_right_avail = tra; left_avail = la;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk(1'b0, "accept_timeout", 288'(n), 288'(200));
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      exp_q.push_back(model(mb, top, left, ta, tra, la));
      lat_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) chk(1'b0, "drain_timeout", 288'(exp_q.size()), 288'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_idle_cleared(input string tag);
    chk(out_valid == 1'b0, {tag, "_out_valid"}, 288'(out_valid), 288'(0));
    chk(in_ready == 1'b1, {tag, "_in_ready"}, 288'(in_ready), 288'(1));
    chk(dbg_state == 2'd0, {tag, "_state"}, 288'(dbg_state), 288'(0));
    chk(best_mode == 2'd0, {tag, "_best_mode"}, 288'(best_mode), 288'(0));
    chk(best_sad == 12'd0, {tag, "_best_sad"}, 288'(best_sad), 288'(0));
    chk(pred_out == '0, {tag, "_pred_out"}, 288'(pred_out), 288'(0));
    chk(resid_out == '0, {tag, "_resid_out"}, 288'(resid_out), 288'(0));
  endtask

  function automatic logic [127:0] rnd_mb(input int lo, input int hi);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'($urandom_range(hi, lo));
    return v;
  endfunction

  // out_ready driver
  initial forever begin
    @(posedge clk); #2;
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int a;
    if (reset) begin
      if (out_valid && !prev_valid) begin
        if (lat_q.size() == 0) chk(1'b0, "latency_no_accept", 288'(cyc), 288'(0));
        else begin
          a = lat_q.pop_front();
          chk(cyc - a == NM, "latency", 288'(cyc - a), 288'(NM));
        end
      end
      if (out_valid) begin
        chk(in_ready == 1'b0, "io_overlap", 288'(in_ready), 288'(0));
        if (exp_q.size() == 0) chk(1'b0, "unexpected_output", 288'(best_mode), 288'(0));
        else begin
          e = exp_q[0];
          chk(best_mode == e[285:284], "best_mode", 288'(best_mode), 288'(e[285:284]));
          chk(best_sad == e[283:272], "best_sad", 288'(best_sad), 288'(e[283:272]));
          chk(pred_out == e[271:144], "pred_out", 288'(pred_out), 288'(e[271:144]));
          chk(resid_out == e[143:0], "resid_out", 288'(resid_out), 288'(e[143:0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
    prev_valid = out_valid;
  end

  initial begin
    #2000000;
    chk(1'b0, "watchdog", 288'(cyc), 288'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [127:0] mb;
    logic [63:0]  tp;
    logic [39:0]  lf;
    int n, v;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_cleared("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // directed cases
    send({16{8'd100}}, {8{8'd100}}, {5{8'd100}}, 1, 1, 1, 1);
    send({16{8'd130}}, {8{8'd77}}, {5{8'd99}}, 0, 0, 0, 1);
    for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) mb[8*(4*y+x) +: 8] = 8'(50 + 10 * y);
    send(mb, 64'd0, {8'd80, 8'd70, 8'd60, 8'd50, 8'd33}, 0, 0, 1, 1);
    tp = {8'd200, 8'd180, 8'd160, 8'd140, 8'd40, 8'd30, 8'd20, 8'd10};
    for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) mb[8*(4*y+x) +: 8] = tp[8*x +: 8];
    send(mb, tp, {5{8'd200}}, 1, 1, 1, 1);
    send(128'd0, {8{8'hff}}, {5{8'hff}}, 1, 1, 1, 1);
    send(128'd0, {8{8'hff}}, {5{8'hff}}, 1, 0, 1, 1);
    wait_drain();

    // stall in DONE with ignored input pulses
    rdy_rand = 1'b0; rdy_force = 1'b0;
    send(rnd_mb(0, 255), {$urandom, $urandom}, 40'({$urandom, $urandom}), 1, 1, 1, 1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk(out_valid == 1'b1, "stall_reach_done", 288'(out_valid), 288'(1));
    repeat (5) begin
      @(posedge clk); #1;
      in_valid = 1'b1; mb_in = rnd_mb(0, 255); top_avail = 1'b0; left_avail = 1'b0;
      @(negedge clk);
      chk(in_ready == 1'b0, "stall_in_ready", 288'(in_ready), 288'(0));
      chk(out_valid == 1'b1, "stall_out_valid", 288'(out_valid), 288'(1));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rdy_force = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(out_valid == 1'b0, "release_out_valid", 288'(out_valid), 288'(0));
    chk(in_ready == 1'b1, "release_in_ready", 288'(in_ready), 288'(1));
    @(posedge clk); #1;
    send(rnd_mb(90, 110), {8{8'd100}}, {5{8'd100}}, 1, 0, 1, 1);
    wait_drain();

    // reset in the second EVAL cycle
    send(rnd_mb(0, 255), {$urandom, $urandom}, 40'({$urandom, $urandom}), 1, 1, 1, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_idle_cleared("midreset");
    @(posedge clk); #1;
    send(rnd_mb(0, 255), {$urandom, $urandom}, 40'({$urandom, $urandom}), 1, 1, 0, 1);
    wait_drain();

    // randomized traffic
    rdy_rand = 1'b1;
    for (int k = 0; k < 150; k++) begin
      v = $urandom_range(0, 2);
      if (v == 0) begin
        mb = rnd_mb(0, 255);
        tp = {$urandom, $urandom};
        lf = 40'({$urandom, $urandom});
      end else begin
        mb = rnd_mb(98, 102);
        for (int i = 0; i < 8; i++) tp[8*i +: 8] = 8'($urandom_range(102, 98));
        for (int i = 0; i < 5; i++) lf[8*i +: 8] = 8'($urandom_range(102, 98));
      end
      send(mb, tp, lf, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/intra4x4_mode_decider.md
Name: intra4x4_mode_decider

Overview:
- Sits directly downstream of the macroblock/neighbour extractor. Consumes one 4x4 luma block, its 8 top neighbours and 5 left neighbours (corner first).
- Builds intra prediction candidates, scores each by SAD against the source block and selects the best mode.
- Emits the chosen mode, its SAD, the prediction block and the signed residual block to the transform stage.
- Valid/ready handshakes on both sides; one block in flight at a time.

Parameters:
- PIX_W, 8, pixel bit width; all widths below assume 8.
- DC_DEFAULT, 128, DC value used when no neighbours are available.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  input block valid
- in_ready  out  1  block can be accepted
- mb_in  in  128  source pixel (x,y) at [8*(4y+x) +: 8]
- top_in  in  64  top neighbours A..H, A at [7:0]
- left_in  in  40  [7:0] = corner M, then I..L (rows 0..3)
- top_avail  in  1  A..D valid
- top_right_avail  in  1  E..H valid
- left_avail  in  1  I..L valid
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- best_mode  out  2  0 = vertical, 1 = horizontal, 2 = DC, 3 = diag-down-left
- best_sad  out  12  SAD of chosen mode (max 16*255 = 4080)
- pred_out  out  128  prediction block, same packing as mb_in
- resid_out  out  144  signed 9-bit (mb - pred) at [9*(4y+x) +: 9]

Behaviour:
- Reset (reset == 0 at a rising edge): state IDLE, in_ready = 1, out_valid = 0. best_mode, best_sad, pred_out and resid_out all cleared to 0. Reset overrides everything, including mid-EVAL and DONE; the in-flight block is discarded.
- FSM states: IDLE, EVAL, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready, register all inputs and availability flags, set mode index = 0, set best SAD = all-ones sentinel, go to EVAL.
- EVAL: in_ready = 0. Each cycle evaluates one mode index, so N = 3 cycles (N = 4 with the optional feature). A mode is legal if:
  - vertical: top_avail
  - horizontal: left_avail
  - DC: always
  - DDL: top_avail
- A legal mode replaces the current best only if its SAD is strictly less than the current best, so ties go to the lowest mode number. On the last index, go to DONE and register best_mode, best_sad, pred_out and resid_out.
- Latency: out_valid is 1 exactly N rising edges after the accepting edge.
- DONE: out_valid = 1; all outputs held stable while out_ready = 0. On out_ready, go to IDLE with out_valid = 0 next cycle; in_ready returns the same cycle. No input/output overlap.
- Predictions:
  - vertical: pred(x,y) = top[x]
  - horizontal: pred(x,y) = left[y+1]
  - DC, both available: (sum A..D + sum I..L + 4) >> 3
  - DC, top only: (sum A..D + 2) >> 2
  - DC, left only: (sum I..L + 2) >> 2
  - DC, neither: DC_DEFAULT
- SAD: sum over 16 pixels of |mb - pred|, 12-bit unsigned, no saturation needed. Residual is 9-bit two's complement, range -255..255.
- in_valid while not in IDLE is ignored; the input is not captured.

Optional Feature:
- Macro INTRA4X4_DDL_EN.
- Defined: mode 3 (diagonal-down-left) is evaluated and N = 4. Let p[0..7] = A..H; if top_right_avail == 0, E..H are replaced by D.
  - pred(3,3) = (p6 + 3*p7 + 2) >> 2
  - all other (x,y): (p[x+y] + 2*p[x+y+1] + p[x+y+2] + 2) >> 2
- Undefined: N = 3, best_mode never equals 3, and top_right_avail is ignored.

Test Plan:
- All neighbours and mb = 100, all avail -> best_mode 0 (tie rule), best_sad 0, resid all 0, out_valid exactly N edges after acceptance.
- No avail, mb all 130 -> best_mode 2, pred all 128, best_sad 32, each residual +2.
- left_avail only, I..L = 50,60,70,80, mb row y = left[y+1] -> best_mode 1, best_sad 0. Vertical is never selected even though top_in = 0.
- top_avail, top = 10,20,30,40, mb rows = top, left_avail with left all 200 -> best_mode 0, sad 0. Also mb all 0 with top = left = 255, both avail -> every mode SAD 4080, mode 0.
- Hold out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready 0, in_valid pulses ignored. Release -> out_valid falls next cycle and the next block is accepted.
- reset low during second EVAL cycle -> next cycle IDLE, out_valid 0, outputs 0. A fresh block then completes normally with correct latency.
